mnist_image_reader: RTL and testbench
=====================================

Name: mnist_image_reader

Overview:
- Reads the 28x28 drawn image out of image_memory through its read port, in row-major order from address 0 to 783.
- Converts each stored pixel to a signed fixed-point activation and streams it to the network input layer over a valid/ready handshake.
- Sits between image_memory (read side) and the first dense-layer loader; the drawing grid owns the write side.
- Also reports the count of set pixels for the HEX displays.

Parameters:
- GRID_SIZE, 28, grid edge length; frame length N = GRID_SIZE*GRID_SIZE = 784.
- READ_LATENCY, 1, cycles from read_addr change to valid mem_data; supported values are 1 and 2.
- ONE_VALUE, 32'sd256, activation emitted for a set pixel (Q8.8 value 1.0).
- FIFO_DEPTH, 4, output skid FIFO depth; must be >= READ_LATENCY+1.

Ports:
- CLOCK_50  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a frame read; ignored while busy=1.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last pixel handshake.
- read_addr  out  16  image_memory read address.
- mem_data  in  32  signed image_memory read data.
- pix_data  out  32  signed activation: ONE_VALUE if mem_data != 0, else 0.
- pix_valid  out  1  pix_data, pix_index and pix_last are valid.
- pix_ready  in  1  downstream accepts the beat when pix_valid && pix_ready.
- pix_last  out  1  high on the beat with index N-1.
- pix_index  out  10  address of the pixel currently presented.
- ones_count  out  10  number of set pixels in the last completed frame.

Behaviour:
- Reset (async, resetn=0): all outputs are 0, the FSM is in IDLE, the FIFO is empty, and the issue and in-flight counters are cleared. When reset is asserted mid-frame, the frame is abandoned with no done pulse, and ones_count returns to 0.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - read_addr is held at 0.
  - On start=1, the FSM clears the issue address, the running count and the FIFO, sets busy=1 next cycle, and moves to FETCH.
- FETCH:
  - A read is issued (read_addr <= issue_addr, issue_addr++) only when fifo_count + inflight < FIFO_DEPTH.
  - The in-flight reads are tracked with a READ_LATENCY-deep valid shift register.
  - Returning data is written into the FIFO together with its address. Returns are never dropped; the occupancy rule above guarantees space.
  - After issuing address N-1, the FSM moves to DRAIN.
- DRAIN: no new issues. When the FIFO is empty and no reads are in flight, the FSM moves to DONE.
- DONE:
  - For one cycle: done=1, busy=0, ones_count <= running count.
  - Then the FSM returns to IDLE.
- Output side:
  - pix_valid = FIFO not empty. pix_data, pix_index and pix_last come from the FIFO head.
  - The head pops on handshake. The outputs are stable while pix_valid=1 and pix_ready=0.
- Running count increments on each handshake whose pix_data != 0; its width is 10 bits (maximum 784, no overflow).
- Simultaneous FIFO push and pop in the same cycle: fifo_count is unchanged.
- A start pulse during busy is ignored with no effect. A start in the same cycle as DONE is also ignored; it is accepted only from IDLE.
- Throughput: with pix_ready held at 1, one beat per cycle.
- Latency: first pix_valid is asserted READ_LATENCY+1 cycles after start.
- Back-to-back frames: a start accepted in the IDLE cycle after DONE re-reads from address 0.
- mem_data is treated as binary. Any nonzero value counts as a set pixel, including negative values.

Test Plan:
- Load memory with 1 at addresses 0, 27, 405 and 783, all others 0; pulse start with pix_ready=1 -> exactly 784 beats with pix_index 0..783 in order. ONE_VALUE (256) appears only at those four indices; pix_last is set only at index 783. done pulses once 1 cycle after the last beat, and ones_count=4.
- Same image with pix_ready toggled on a pseudo-random 30% duty -> identical beat sequence, and pix_data/pix_index stay stable on every stalled cycle. fifo_count never exceeds FIFO_DEPTH; ones_count=4.
- Hold pix_ready=0 for 100 cycles after start -> reads stop after FIFO_DEPTH entries are issued. After release, no pixel is lost or duplicated.
- Pulse start again at beat 300 -> ignored, the frame completes normally, and exactly one done pulse occurs.
- Assert resetn=0 at beat 500, release, then pulse start -> all outputs 0 during reset and no done for the aborted frame. The new frame restarts at index 0 and completes with the correct count.
- All-ones image with READ_LATENCY=2 -> 784 beats all equal to 256, ones_count=784; first pix_valid is 3 cycles after start.

Source files
------------

// File: rtl/mnist_image_reader.sv
`default_nettype none
// ============================================================================
// Module   : mnist_image_reader
// Purpose  : Streams the 28x28 drawn image out of image_memory in row-major
//            order (address 0..N-1). Each stored word becomes a Q8.8
//            activation (ONE_VALUE if nonzero, else 0). Pixels leave through
//            a valid/ready handshake behind a small skid FIFO. The module
//            also reports how many pixels were set in the last frame.
// Ports    : CLOCK_50   - system clock, rising edge
//            resetn     - asynchronous active-low reset
//            start      - one-cycle pulse, accepted only in IDLE
//            busy       - frame in progress
//            done       - one-cycle pulse after the last pixel handshake
//            read_addr  - image_memory read address
//            mem_data   - image_memory read data (READ_LATENCY cycles late)
//            pix_data   - activation for the presented pixel
//            pix_valid  - pix_data/pix_index/pix_last valid
//            pix_ready  - downstream accepts the beat
//            pix_last   - presented pixel is index N-1
//            pix_index  - address of the presented pixel
//            ones_count - set pixels in the last completed frame
// Revision : 1.0 - initial release
// ============================================================================
module mnist_image_reader #(
  parameter int                 GRID_SIZE    = 28,
  parameter int                 READ_LATENCY = 1,
  parameter logic signed [31:0] ONE_VALUE    = 32'sd256,
  parameter int                 FIFO_DEPTH   = 4
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [15:0]        read_addr,
  input  logic signed [31:0] mem_data,
  output logic signed [31:0] pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_last,
  output logic [9:0]         pix_index,
  output logic [9:0]         ones_count
);

  localparam int                   c_N       = GRID_SIZE * GRID_SIZE;
  localparam int                   c_PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                   c_CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [9:0]           c_LAST    = 10'(c_N - 1);
  localparam logic [c_CNT_W:0]     c_DEPTH   = (c_CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [c_PTR_W-1:0]   c_PTR_MAX = c_PTR_W'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    r_state;
  logic [9:0]                r_issue_addr;
  logic [9:0]                r_ret_addr;    // address of the next returning word (reads return in order)
  logic [READ_LATENCY-1:0]   r_vld;         // one bit per outstanding read stage
  logic [c_CNT_W-1:0]        r_inflight;
  logic [c_PTR_W-1:0]        r_wr_ptr;
  logic [c_PTR_W-1:0]        r_rd_ptr;
  logic [c_CNT_W-1:0]        r_fifo_count;
  logic [9:0]                r_run_count;
  logic                      r_fifo_set [FIFO_DEPTH];
  logic [9:0]                r_fifo_idx [FIFO_DEPTH];

  logic               w_issue;
  logic               w_ret;
  logic               w_pop;
  logic               w_head_set;
  logic [9:0]         w_head_idx;
  logic [c_CNT_W:0]   w_occ;
  logic [9:0]         w_run_next;
  logic               w_drained;

  function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] p);
    return (p == c_PTR_MAX) ? '0 : p + c_PTR_W'(1);
  endfunction

  // Reserving a FIFO slot for every outstanding read means a return always
  // finds space, so returns never need back-pressure.
  assign w_occ      = {1'b0, r_fifo_count} + {1'b0, r_inflight};
  assign w_issue    = (r_state == S_FETCH) && (w_occ < c_DEPTH);
  assign w_ret      = r_vld[READ_LATENCY-1];
  assign w_head_set = r_fifo_set[r_rd_ptr];
  assign w_head_idx = r_fifo_idx[r_rd_ptr];
  assign pix_valid  = (r_fifo_count != '0);
  assign w_pop      = pix_valid && pix_ready;
  assign w_run_next = (w_pop && w_head_set) ? r_run_count + 10'd1 : r_run_count;
  // FIFO is empty now or empties on this edge; with nothing in flight no push can refill it.
  assign w_drained  = (r_fifo_count == '0) ||
                      ((r_fifo_count == c_CNT_W'(1)) && w_pop);

  // Outputs are forced to zero while nothing is presented so stale FIFO
  // contents never show on the bus.
  assign pix_data  = (pix_valid && w_head_set) ? ONE_VALUE : '0;
  assign pix_index = pix_valid ? w_head_idx : '0;
  assign pix_last  = pix_valid && (w_head_idx == c_LAST);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      read_addr    <= '0;
      ones_count   <= '0;
      r_issue_addr <= '0;
      r_ret_addr   <= '0;
      r_vld        <= '0;
      r_inflight   <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_fifo_count <= '0;
      r_run_count  <= '0;
    end else begin
      done        <= 1'b0;
      r_vld       <= READ_LATENCY'({r_vld, w_issue});
      r_run_count <= w_run_next;

      case ({w_issue, w_ret})
        2'b10:   r_inflight <= r_inflight + c_CNT_W'(1);
        2'b01:   r_inflight <= r_inflight - c_CNT_W'(1);
        default: r_inflight <= r_inflight;
      endcase

      if (w_ret) begin
        r_wr_ptr   <= next_ptr(r_wr_ptr);
        r_ret_addr <= r_ret_addr + 10'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_ret, w_pop})
        2'b10:   r_fifo_count <= r_fifo_count + c_CNT_W'(1);
        2'b01:   r_fifo_count <= r_fifo_count - c_CNT_W'(1);
        default: r_fifo_count <= r_fifo_count;
      endcase

      case (r_state)
        S_IDLE: begin
          read_addr <= '0;
          if (start) begin
            r_issue_addr <= '0;
            r_ret_addr   <= '0;
            r_run_count  <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
            busy         <= 1'b1;
            r_state      <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_issue) begin
            read_addr    <= 16'(r_issue_addr);
            r_issue_addr <= r_issue_addr + 10'd1;
            if (r_issue_addr == c_LAST) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((r_inflight == '0) && w_drained) begin
            done       <= 1'b1;
            busy       <= 1'b0;
            ones_count <= w_run_next;
            r_state    <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Payload storage needs no reset: pix_valid masks every unwritten slot.
  always_ff @(posedge CLOCK_50) begin
    if (w_ret) begin
      r_fifo_set[r_wr_ptr] <= (mem_data != '0);
      r_fifo_idx[r_wr_ptr] <= r_ret_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mnist_image_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mnist_image_reader
// Purpose  : Self-checking bench for mnist_image_reader. A latency-1 instance
//            runs the directed frame sequence; a latency-2 instance reads an
//            all-nonzero image. Expected beats are queued when a frame is
//            started and compared whenever the DUT presents a pixel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mnist_image_reader;

  localparam int c_N = 784;

  logic               CLOCK_50 = 1'b0;
  logic               resetn;
  logic               start;
  logic               pix_ready;
  logic               busy, done, pix_valid, pix_last;
  logic [15:0]        read_addr;
  logic signed [31:0] mem_data, pix_data;
  logic [9:0]         pix_index, ones_count;

  logic               start2;
  logic               pix_ready2;
  logic               busy2, done2, pix_valid2, pix_last2;
  logic [15:0]        read_addr2;
  logic signed [31:0] mem_data2, pix_data2;
  logic [9:0]         pix_index2, ones_count2;

  logic signed [31:0] mem  [0:c_N-1];
  logic signed [31:0] mem2 [0:c_N-1];
  logic signed [31:0] mem2_q;

  logic [63:0] q  [$];
  logic [63:0] q2 [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int beats_total = 0;
  int beat_base = 0;
  int last_cyc = -10;
  int n_done = 0;
  int beats2 = 0;
  int n_done2 = 0;
  int exp_ones = 0;
  int occ_m;

  always #10 CLOCK_50 = ~CLOCK_50;

  // Combinational read: data for read_addr is sampled on the next edge.
  assign mem_data = mem[read_addr[9:0]];
  // One extra register stage models a two-cycle memory.
  always @(posedge CLOCK_50) mem2_q <= mem2[read_addr2[9:0]];
  assign mem_data2 = mem2_q;

  mnist_image_reader #(.READ_LATENCY(1)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .busy(busy), .done(done),
    .read_addr(read_addr), .mem_data(mem_data), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
    .pix_index(pix_index), .ones_count(ones_count)
  );

  mnist_image_reader #(.READ_LATENCY(2)) dut2 (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start2), .busy(busy2), .done(done2),
    .read_addr(read_addr2), .mem_data(mem_data2), .pix_data(pix_data2),
    .pix_valid(pix_valid2), .pix_ready(pix_ready2), .pix_last(pix_last2),
    .pix_index(pix_index2), .ones_count(ones_count2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor for the latency-1 instance, sampling on the falling edge.
  always @(negedge CLOCK_50) begin
    cyc++;
    if (resetn) begin
      if (busy) begin
        occ_m = int'(read_addr) + 1 - (beats_total - beat_base);
        chk("occupancy_le_depth", 64'(occ_m <= 4), 64'd1);
      end
      if (pix_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 64'(q.size()), 64'd1);
        end else begin
          chk("beat", {21'd0, pix_last, pix_index, pix_data}, q[0]);
          if (pix_ready) begin
            void'(q.pop_front());
            beats_total++;
            if (pix_last) last_cyc = cyc;
          end
        end
      end
      if (done) begin
        n_done++;
        chk("done_after_last_beat", 64'(cyc), 64'(last_cyc + 1));
        chk("busy_low_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Monitor for the latency-2 instance.
  always @(negedge CLOCK_50) begin
    if (resetn) begin
      if (pix_valid2) begin
        if (q2.size() == 0) begin
          chk("unexpected_beat2", 64'(q2.size()), 64'd1);
        end else begin
          chk("beat2", {21'd0, pix_last2, pix_index2, pix_data2}, q2[0]);
          if (pix_ready2) begin
            void'(q2.pop_front());
            beats2++;
          end
        end
      end
      if (done2) n_done2++;
    end
  end

  task automatic push_expected();
    logic [31:0] d;
    exp_ones = 0;
    for (int i = 0; i < c_N; i++) begin
      d = (mem[i] != 0) ? 32'd256 : 32'd0;
      if (mem[i] != 0) exp_ones++;
      q.push_back({21'd0, (i == c_N - 1), 10'(i), d});
    end
    beat_base = beats_total;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    push_expected();
    @(posedge CLOCK_50); #1;
    start = 1'b0;
  endtask

  task automatic measure_latency(input int exp_lat);
    int lat;
    lat = 0;
    while (!pix_valid && lat < 10) begin
      @(posedge CLOCK_50); #1;
      lat++;
    end
    chk("first_valid_latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int k;
    k = 0;
    while (!done && k < budget) begin
      if (rnd) pix_ready = ($urandom_range(0, 9) < 3);
      @(posedge CLOCK_50); #1;
      k++;
    end
    chk("done_within_budget", 64'(k < budget), 64'd1);
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while ((beats_total - beat_base) < n && k < 5000) begin
      @(posedge CLOCK_50); #1;
      k++;
    end
    chk("beat_wait_within_budget", 64'(k < 5000), 64'd1);
  endtask

  task automatic frame_end_checks(input string tag);
    chk({tag, "_ones_count"}, 64'(ones_count), 64'(exp_ones));
    chk({tag, "_beat_count"}, 64'(beats_total - beat_base), 64'(c_N));
    chk({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {26'd0, busy, done, read_addr, ones_count, busy2, done2, ones_count2}, 64'd0);
    chk({tag, "_pix"}, {21'd0, pix_valid, pix_last, pix_index, pix_data}, 64'd0);
    chk({tag, "_pix2"}, {21'd0, pix_valid2, pix_last2, pix_index2, pix_data2}, 64'd0);
  endtask

  initial begin
    int done_before;
    int k;
    for (int i = 0; i < c_N; i++) begin
      mem[i]  = 32'sd0;
      mem2[i] = (i % 3 == 0) ? -32'sd1 : 32'(i + 1);
    end
    mem[0] = 32'sd1; mem[27] = 32'sd1; mem[405] = 32'sd1; mem[783] = 32'sd1;

    resetn = 1'b0; start = 1'b0; pix_ready = 1'b0; start2 = 1'b0; pix_ready2 = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_reset_outputs("initial_reset");
    resetn = 1'b1;
    repeat (2) @(posedge CLOCK_50);
    #1;

    // Frame 1: ready held high, four set pixels.
    pix_ready = 1'b1;
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    measure_latency(2);
    wait_done(3000, 1'b0);
    frame_end_checks("f1");
    chk("f1_ones_is_4", 64'(ones_count), 64'd4);
    @(posedge CLOCK_50); #1;
    chk("f1_done_single_cycle", 64'(done), 64'd0);

    // Frame 2: ready on a 30% random duty.
    repeat (2) @(posedge CLOCK_50);
    #1;
    pulse_start();
    wait_done(10000, 1'b1);
    pix_ready = 1'b1;
    frame_end_checks("f2");

    // Frame 3: 100-cycle stall after start, then a spurious start at beat 300.
    repeat (2) @(posedge CLOCK_50);
    #1;
    done_before = n_done;
    pix_ready = 1'b0;
    pulse_start();
    repeat (100) @(posedge CLOCK_50);
    #1;
    chk("stall_read_addr_stops", 64'(read_addr), 64'd3);
    chk("stall_head", {53'd0, pix_valid, pix_index}, {53'd0, 1'b1, 10'd0});
    chk("stall_busy", 64'(busy), 64'd1);
    pix_ready = 1'b1;
    wait_beats(300);
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    chk("busy_start_ignored", 64'(busy), 64'd1);
    wait_done(3000, 1'b0);
    frame_end_checks("f3");
    repeat (20) @(posedge CLOCK_50);
    #1;
    chk("f3_one_done_pulse", 64'(n_done - done_before), 64'd1);

    // Frame 4: reset at beat 500 abandons the frame.
    pulse_start();
    wait_beats(500);
    done_before = n_done;
    resetn = 1'b0;
    q.delete();
    #1;
    check_reset_outputs("midframe_reset");
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_reset_outputs("midframe_reset_hold");
    resetn = 1'b1;
    repeat (10) @(posedge CLOCK_50);
    #1;
    chk("aborted_no_done", 64'(n_done - done_before), 64'd0);
    chk("aborted_idle", {54'd0, busy, pix_valid, ones_count}, 64'd0);

    // New image with negative words, which also count as set.
    mem[100] = -32'sd7;
    mem[200] = 32'sh8000_0000;
    pulse_start();
    measure_latency(2);
    wait_done(3000, 1'b0);
    frame_end_checks("f4");
    chk("f4_ones_is_6", 64'(ones_count), 64'd6);

    // Start held across DONE: ignored in DONE, accepted in the next IDLE cycle.
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    chk("start_in_done_ignored", 64'(busy), 64'd0);
    push_expected();
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    chk("back_to_back_accepted", 64'(busy), 64'd1);
    wait_done(3000, 1'b0);
    frame_end_checks("f5");

    // Latency-2 instance, all-nonzero image.
    for (int i = 0; i < c_N; i++) q2.push_back({21'd0, (i == c_N - 1), 10'(i), 32'd256});
    @(posedge CLOCK_50); #1;
    start2 = 1'b1;
    @(posedge CLOCK_50); #1;
    start2 = 1'b0;
    k = 0;
    while (!pix_valid2 && k < 10) begin
      @(posedge CLOCK_50); #1;
      k++;
    end
    chk("lat2_first_valid_latency", 64'(k), 64'd3);
    k = 0;
    while (!done2 && k < 3000) begin
      @(posedge CLOCK_50); #1;
      k++;
    end
    chk("lat2_done_within_budget", 64'(k < 3000), 64'd1);
    chk("lat2_ones_count", 64'(ones_count2), 64'd784);
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("lat2_beats", 64'(beats2), 64'd784);
    chk("lat2_queue_empty", 64'(q2.size()), 64'd0);
    chk("lat2_done_count", 64'(n_done2), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
